// File: rtl/ioctl_dl_router.sv
// Routes hps_io ioctl bytes to power-of-two ROM regions, DIP and mod latches; sequences core reset.
// All outputs registered, one clk_sys after the ioctl sample; no backpressure, every write strobe is consumed.
module ioctl_dl_router #(
    parameter int                     REGIONS     = 4,
    parameter int                     REGION_AW   = 15,
    parameter int                     DIP_BYTES   = 8,
    parameter logic [8*DIP_BYTES-1:0] DIP_DEFAULT = '0,
    parameter int                     HOLD_CYCLES = 256,
    parameter logic [7:0]             ROM_INDEX   = 8'd0,
    parameter logic [7:0]             MOD_INDEX   = 8'd1,
    parameter logic [7:0]             DIP_INDEX   = 8'd254
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     ioctl_download,
    input  logic [7:0]               ioctl_index,
    input  logic                     ioctl_wr,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    input  logic                     ext_reset,
    output logic [REGIONS-1:0]       rgn_wr,
    output logic [REGION_AW-1:0]     rgn_addr,
    output logic [7:0]               rgn_data,
    output logic [8*DIP_BYTES-1:0]   dip,
    output logic [7:0]               mod_byte,
    output logic                     core_reset,
    output logic                     rom_loading,
    output logic                     rom_loaded,
    output logic                     rom_overflow,
    output logic [24:0]              rom_bytes
);

    localparam int SEL_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [31:0]      ROM_LIMIT = 32'(REGIONS) << REGION_AW;
    localparam logic [31:0]      DIP_LIMIT = 32'(DIP_BYTES);

    typedef enum logic [1:0] {IDLE, ROM, HOLD, RUN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               dl_q;
    logic [7:0]         cur_idx;
    logic               dl_rise;
    logic               rom_start;
    logic               rom_wr_en;
    logic               in_range;
    logic               dip_wr;
    logic               mod_wr;
    logic [SEL_W-1:0]   sel;

    // dl_q resets high so a download still active at reset release is not taken as a new start.
    assign dl_rise   = ioctl_download & ~dl_q;
    assign rom_start = dl_rise && (ioctl_index == ROM_INDEX);
    assign rom_wr_en = (state == ROM) && ioctl_wr;
    assign in_range  = {7'd0, ioctl_addr} < ROM_LIMIT;
    assign dip_wr    = ioctl_wr && (cur_idx == DIP_INDEX) && ({7'd0, ioctl_addr} < DIP_LIMIT);
    assign mod_wr    = ioctl_wr && (cur_idx == MOD_INDEX);

    generate
        if (REGIONS > 1) begin : g_sel
            assign sel = ioctl_addr[REGION_AW +: SEL_W];
        end else begin : g_sel_one
            assign sel = '0;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (rom_start) begin
                    state_nxt = ROM;
                end else begin
                    state_nxt = HOLD;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ROM: begin
                if (!ioctl_download) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            HOLD: begin
                if (ext_reset) begin
                    cnt_nxt = CNT_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RUN: begin
                if (rom_start) begin
                    state_nxt = ROM;
                end else if (ext_reset) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dl_q       <= 1'b1;
            cur_idx    <= '0;
            core_reset <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dl_q       <= ioctl_download;
            core_reset <= (state_nxt != RUN) | ext_reset;
            if (dl_rise) begin
                cur_idx <= ioctl_index;
            end
        end
    end

    assign rom_loading = (state == ROM);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rgn_wr       <= '0;
            rgn_addr     <= '0;
            rgn_data     <= '0;
            rom_loaded   <= 1'b0;
            rom_overflow <= 1'b0;
            rom_bytes    <= '0;
        end else begin
            rgn_wr <= '0;
            if (state_nxt == ROM && state != ROM) begin
                rom_overflow <= 1'b0;
                rom_bytes    <= '0;
            end
            if (state == ROM && state_nxt == HOLD) begin
                rom_loaded <= 1'b1;
            end
            if (rom_wr_en) begin
                if (in_range) begin
                    rgn_wr   <= REGIONS'(1) << sel;
                    rgn_addr <= ioctl_addr[REGION_AW-1:0];
                    rgn_data <= ioctl_dout;
                    if (rom_bytes != '1) begin
                        rom_bytes <= rom_bytes + 25'd1;
                    end
                end else begin
                    rom_overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dip      <= DIP_DEFAULT;
            mod_byte <= '0;
        end else begin
            for (int k = 0; k < DIP_BYTES; k++) begin
                if (dip_wr && ioctl_addr == 25'(k)) begin
                    dip[8*k +: 8] <= ioctl_dout;
                end
            end
            if (mod_wr) begin
                mod_byte <= ioctl_dout;
            end
        end
    end

endmodule

// File: tb/tb_ioctl_dl_router.sv
// Directed bench for ioctl_dl_router: routing, overflow, DIP/mod latches, hold timing and resets.
module tb_ioctl_dl_router;

    localparam logic [63:0] DIP_DEF = 64'h0123_4567_89AB_CDEF;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ext_reset;
    logic [3:0]  rgn_wr;
    logic [14:0] rgn_addr;
    logic [7:0]  rgn_data;
    logic [63:0] dip;
    logic [7:0]  mod_byte;
    logic        core_reset;
    logic        rom_loading;
    logic        rom_loaded;
    logic        rom_overflow;
    logic [24:0] rom_bytes;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk_sys = ~clk_sys;

    ioctl_dl_router #(
        .DIP_DEFAULT (DIP_DEF)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ext_reset      (ext_reset),
        .rgn_wr         (rgn_wr),
        .rgn_addr       (rgn_addr),
        .rgn_data       (rgn_data),
        .dip            (dip),
        .mod_byte       (mod_byte),
        .core_reset     (core_reset),
        .rom_loading    (rom_loading),
        .rom_loaded     (rom_loaded),
        .rom_overflow   (rom_overflow),
        .rom_bytes      (rom_bytes)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    // Counts consecutive sampled cycles with core_reset high, starting at the current sample.
    task automatic count_high(output int cnt);
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            if (!core_reset) break;
            cnt++;
            tick();
        end
    endtask

    task automatic wait_run(input string tag);
        for (int i = 0; i < 600; i++) begin
            if (!core_reset) break;
            tick();
        end
        chk(tag, core_reset, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rgn_wr"},   rgn_wr, 0);
        chk({tag, "_rgn_addr"}, rgn_addr, 0);
        chk({tag, "_rgn_data"}, rgn_data, 0);
        chk({tag, "_dip"},      dip, DIP_DEF);
        chk({tag, "_mod"},      mod_byte, 0);
        chk({tag, "_core_rst"}, core_reset, 1);
        chk({tag, "_loading"},  rom_loading, 0);
        chk({tag, "_loaded"},   rom_loaded, 0);
        chk({tag, "_ovf"},      rom_overflow, 0);
        chk({tag, "_bytes"},    rom_bytes, 0);
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ext_reset      = 1'b0;
        repeat (3) tick();
        check_reset_values("por");

        // Power-up hold: HOLD_CYCLES samples of core_reset after the release edge.
        reset_n = 1'b1;
        tick();
        count_high(n);
        chk("por_hold_len", n, 256);
        chk("por_dip", dip, DIP_DEF);

        // ROM download with back-to-back writes; last write coincides with download falling.
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        chk("rom_loading_on", rom_loading, 1);
        chk("rom_core_rst", core_reset, 1);
        wr_byte(25'h0000, 8'hA5);
        chk("w0_wr", rgn_wr, 4'b0001); chk("w0_addr", rgn_addr, 15'h0000); chk("w0_data", rgn_data, 8'hA5);
        wr_byte(25'h7FFF, 8'h5A);
        chk("w1_wr", rgn_wr, 4'b0001); chk("w1_addr", rgn_addr, 15'h7FFF); chk("w1_data", rgn_data, 8'h5A);
        wr_byte(25'h8000, 8'h11);
        chk("w2_wr", rgn_wr, 4'b0010); chk("w2_addr", rgn_addr, 15'h0000); chk("w2_data", rgn_data, 8'h11);
        ioctl_download = 1'b0;
        wr_byte(25'h1FFFF, 8'h22);
        chk("w3_wr", rgn_wr, 4'b1000); chk("w3_addr", rgn_addr, 15'h7FFF); chk("w3_data", rgn_data, 8'h22);
        chk("rom_loading_off", rom_loading, 0);
        chk("rom_loaded_set", rom_loaded, 1);
        chk("rom_bytes4", rom_bytes, 4);
        count_high(n);
        chk("rom_hold_len", n, 256);
        chk("rom_loaded_run", rom_loaded, 1);
        chk("rom_bytes_run", rom_bytes, 4);

        // Overflow: byte beyond the last region is dropped and flagged.
        ioctl_download = 1'b1;
        tick();
        chk("ovf_bytes_clr", rom_bytes, 0);
        wr_byte(25'h0010, 8'h33);
        chk("ovf_pre_wr", rgn_wr, 4'b0001);
        wr_byte(25'h20000, 8'h44);
        chk("ovf_no_wr", rgn_wr, 4'b0000);
        chk("ovf_flag", rom_overflow, 1);
        chk("ovf_bytes", rom_bytes, 1);
        ioctl_download = 1'b0;
        tick();
        wait_run("ovf_wait_run");
        chk("ovf_sticky", rom_overflow, 1);
        ioctl_download = 1'b1;
        tick();
        chk("ovf_clr", rom_overflow, 0);
        ioctl_download = 1'b0;
        tick();
        wait_run("ovf2_wait_run");

        // DIP bytes 0 and 7 land, 8 is dropped; core stays running.
        ioctl_index    = 8'd254;
        ioctl_download = 1'b1;
        tick();
        wr_byte(25'd0, 8'hC2);
        chk("dip0", dip[7:0], 8'hC2);
        wr_byte(25'd7, 8'h3F);
        chk("dip7", dip[63:56], 8'h3F);
        wr_byte(25'd8, 8'hFF);
        chk("dip_all", dip, 64'h3F23_4567_89AB_CDC2);
        chk("dip_core_rst", core_reset, 0);
        chk("dip_no_rgn", rgn_wr, 4'b0000);
        ioctl_download = 1'b0;
        tick();

        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        tick();
        wr_byte(25'd0, 8'h01);
        chk("mod01", mod_byte, 8'h01);
        wr_byte(25'd3, 8'h7E);
        chk("mod7e", mod_byte, 8'h7E);
        chk("mod_dip_keep", dip, 64'h3F23_4567_89AB_CDC2);
        ioctl_download = 1'b0;
        tick();

        // Reset mid ROM download; download stays high so no new start is seen.
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        wr_byte(25'h0100, 8'h77);
        chk("mid_wr", rgn_wr, 4'b0001);
        reset_n    = 1'b0;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h0200;
        ioctl_dout = 8'h66;
        tick();
        ioctl_wr   = 1'b0;
        check_reset_values("mid");
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_byte(25'h0005 + 25'(i), 8'h99);
            chk("mid_ignored", rgn_wr, 4'b0000);
        end
        chk("mid_not_loading", rom_loading, 0);
        wait_run("mid_wait_run");
        chk("mid_bytes", rom_bytes, 0);
        ioctl_download = 1'b0;
        tick();

        // ext_reset pulse of 3 cycles in RUN, then a full hold after it ends.
        ext_reset = 1'b1;
        chk("ext_lat", core_reset, 0);
        tick();
        chk("ext_p0", core_reset, 1);
        tick();
        tick();
        chk("ext_p2", core_reset, 1);
        ext_reset = 1'b0;
        count_high(n);
        chk("ext_hold_len", n, 256);
        chk("ext_run", core_reset, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
